// File: rtl/xgmii_tx_arb2.sv
// Two-port round-robin frame arbiter feeding one XGMII TX bus.
// Frame-boundary switching, enforced idle gap, underrun abort.
module xgmii_tx_arb2 #(
  parameter int IFG_WORDS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             xgmii_tx_clk,
  input  logic             sys_rst,
  input  logic [71:0]      dout0,
  input  logic             empty0,
  output logic             rd_en0,
  input  logic [71:0]      dout1,
  input  logic             empty1,
  output logic             rd_en1,
  output logic [71:0]      xgmii_txd,
  output logic             grant,
  output logic             busy,
  output logic             underrun,
  output logic             stray,
  output logic [CNT_W-1:0] frames0,
  output logic [CNT_W-1:0] frames1,
  output logic [CNT_W-1:0] errors0,
  output logic [CNT_W-1:0] errors1
);

  localparam logic [71:0] IDLE_W = 72'hff_07070707_07070707;
  localparam logic [71:0] ERR_W  = 72'hff_fefefefe_fefefefe;
  localparam int GW = (IFG_WORDS > 1) ? $clog2(IFG_WORDS) : 1;
  localparam logic [GW-1:0] GAP_INIT =
    (IFG_WORDS > 0) ? GW'(IFG_WORDS - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DROP,
    S_IFG
  } state_t;

  state_t        state;
  logic [GW-1:0] gap;

  logic        cand;
  logic        any;
  logic        empty_g;
  logic [71:0] head_c;
  logic [71:0] head_g;
  logic        pop0;
  logic        pop1;

  function automatic logic is_sof(input logic [71:0] w);
    return w[64] && (w[7:0] == 8'hFB);
  endfunction

  function automatic logic is_eof(input logic [71:0] w);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 8; i++)
      if (w[64+i] && (w[8*i +: 8] == 8'hFD))
        r = 1'b1;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // Round-robin candidate: on a tie the port that did not own the last frame.
  always_comb begin
    any  = !empty0 || !empty1;
    cand = 1'b0;
    if (!empty0 && !empty1)
      cand = ~grant;
    else if (empty0)
      cand = 1'b1;
    head_c  = cand  ? dout1  : dout0;
    head_g  = grant ? dout1  : dout0;
    empty_g = grant ? empty1 : empty0;
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (!sys_rst) begin
      unique case (state)
        S_IDLE: begin
          pop0 = any && !cand;
          pop1 = any && cand;
        end
        S_SEND, S_DROP: begin
          pop0 = !grant && !empty0;
          pop1 = grant && !empty1;
        end
        default: ;
      endcase
    end
  end

  assign rd_en0 = pop0;
  assign rd_en1 = pop1;

  always_ff @(posedge xgmii_tx_clk) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      gap       <= '0;
      xgmii_txd <= IDLE_W;
      grant     <= 1'b1;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      stray     <= 1'b0;
      frames0   <= '0;
      frames1   <= '0;
      errors0   <= '0;
      errors1   <= '0;
    end else begin
      underrun <= 1'b0;
      stray    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          xgmii_txd <= IDLE_W;
          if (any) begin
            if (is_sof(head_c)) begin
              xgmii_txd <= head_c;
              grant     <= cand;
              if (is_eof(head_c)) begin
                if (cand) frames1 <= sat(frames1);
                else      frames0 <= sat(frames0);
                if (IFG_WORDS > 0) begin
                  state <= S_IFG;
                  gap   <= GAP_INIT;
                end
              end else begin
                state <= S_SEND;
                busy  <= 1'b1;
              end
            end else begin
              stray <= 1'b1;
              if (cand) errors1 <= sat(errors1);
              else      errors0 <= sat(errors0);
            end
          end
        end
        S_SEND: begin
          if (!empty_g) begin
            xgmii_txd <= head_g;
            if (is_eof(head_g)) begin
              if (grant) frames1 <= sat(frames1);
              else       frames0 <= sat(frames0);
              busy <= 1'b0;
              if (IFG_WORDS > 0) begin
                state <= S_IFG;
                gap   <= GAP_INIT;
              end else begin
                state <= S_IDLE;
              end
            end
          end else begin
            xgmii_txd <= ERR_W;
            underrun  <= 1'b1;
            state     <= S_DROP;
            if (grant) errors1 <= sat(errors1);
            else       errors0 <= sat(errors0);
          end
        end
        S_DROP: begin
          xgmii_txd <= IDLE_W;
          if (!empty_g && is_eof(head_g)) begin
            busy <= 1'b0;
            if (IFG_WORDS > 0) begin
              state <= S_IFG;
              gap   <= GAP_INIT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_IFG: begin
          xgmii_txd <= IDLE_W;
          if (gap == '0) state <= S_IDLE;
          else           gap   <= gap - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
